gate2_tester: RTL

//   Stimulus and checker for an external 2-input gate (e.g. the nor2 fabric block).

---
 rtl/gate2_tester_pkg.sv | 22 ++
 rtl/gate2_tester_bit_sync.sv | 24 ++
 rtl/gate2_tester.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gate2_tester_pkg.sv
// Shared types and constants for the 2-input gate self-test block.
package gate2_tester_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int NVEC = 4;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic int cnt_width(input int h);
    return (h <= 1) ? 1 : $clog2(h);
  endfunction

endpackage

// File: rtl/gate2_tester_bit_sync.sv
// N-flop synchronizer for an asynchronous single-bit input, synchronous reset to 0.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // shift chain; the shift-and-or form also covers STAGES == 1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(i_d);
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/gate2_tester.sv
// Walks all four input vectors through an external 2-input gate and checks
// each synchronized output sample against the TRUTH table.
module gate2_tester
  import gate2_tester_pkg::*;
#(
  parameter logic [3:0] TRUTH       = TT_NOR,
  parameter int         SETTLE      = 1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_a_out,
  output logic       o_b_out,
  input  logic       i_y_in,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_fail_mask,
  output logic [1:0] o_vec_idx
);

  localparam int H  = SETTLE + SYNC_STAGES + 1;
  localparam int CW = cnt_width(H);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_vec, w_vec_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_pass, w_pass_nxt;
  logic [3:0]    r_mask, w_mask_nxt;
  logic [3:0]    w_mask_upd;
  logic          w_last;
  logic          w_y_sync;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_y_in),
    .o_q   (w_y_sync)
  );

  // state and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_vec   <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_mask  <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  // next-state logic; FIN accepts start just like IDLE so runs chain back-to-back
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_vec_nxt         = r_vec;
    w_busy_nxt        = r_busy;
    w_done_nxt        = 1'b0;
    w_pass_nxt        = r_pass;
    w_mask_nxt        = r_mask;
    w_last            = (r_cnt == CW'(H - 1));
    w_mask_upd        = r_mask;
    w_mask_upd[r_vec] = (w_y_sync != TRUTH[r_vec]);

    case (r_state)
      IDLE, FIN: begin
        if (i_start) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
          w_vec_nxt   = 2'd0;
          w_busy_nxt  = 1'b1;
          w_mask_nxt  = 4'b0000;
          w_pass_nxt  = 1'b0;
        end else begin
          w_state_nxt = IDLE;
          w_vec_nxt   = 2'd0;
          w_busy_nxt  = 1'b0;
        end
      end
      RUN: begin
        if (w_last) begin
          w_mask_nxt = w_mask_upd;
          if (r_vec == 2'(NVEC - 1)) begin
            w_state_nxt = FIN;
            w_vec_nxt   = 2'd0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = ~|w_mask_upd;
          end else begin
            w_vec_nxt = r_vec + 2'd1;
            w_cnt_nxt = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_vec_nxt   = 2'd0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_a_out     = r_vec[1];
  assign o_b_out     = r_vec[0];
  assign o_vec_idx   = r_vec;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_fail_mask = r_mask;

endmodule
